dmux_sched: RTL

//  Round-robin scheduler for the 16-bit 1-to-3 demultiplexer datapath.

---
 rtl/dmux_sched.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dmux_sched.sv
// Purpose: round-robin scheduler for a 1-to-3 demux; holds one word and grants it to an enabled, ready channel.
// Latency: word accepted at edge N is offered from cycle N+1; pass-through sustains 1 word/clk.
// Backpressure: in_ready drops while a held word has no eligible channel; words are never dropped.
// Optional: define DMUX_SCHED_CNT_EN to add per-channel transfer counters cnt0..cnt2.
module dmux_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ch_en,
    input  logic [2:0]       ch_ready,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_valid
`ifdef DMUX_SCHED_CNT_EN
    ,
    output logic [WIDTH-1:0] cnt0,
    output logic [WIDTH-1:0] cnt1,
    output logic [WIDTH-1:0] cnt2
`endif
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           state;
    logic [1:0]       rr_ptr;
    logic [WIDTH-1:0] hold_reg;
    logic             rdy_en;     // low during reset and the first cycle after release
    logic [2:0]       elig;
    logic             gnt_vld;
    logic [1:0]       gnt_idx;
    logic [1:0]       gnt_next;
    logic             transfer;
    logic             accept;

    // Grant search: first eligible channel in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3)
    always_comb begin
        elig    = ch_en & ch_ready;
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        case (rr_ptr)
            2'd1: begin
                if (elig[1])      begin gnt_vld = 1'b1; gnt_idx = 2'd1; end
                else if (elig[2]) begin gnt_vld = 1'b1; gnt_idx = 2'd2; end
                else if (elig[0]) begin gnt_vld = 1'b1; gnt_idx = 2'd0; end
            end
            2'd2: begin
                if (elig[2])      begin gnt_vld = 1'b1; gnt_idx = 2'd2; end
                else if (elig[0]) begin gnt_vld = 1'b1; gnt_idx = 2'd0; end
                else if (elig[1]) begin gnt_vld = 1'b1; gnt_idx = 2'd1; end
            end
            default: begin
                if (elig[0])      begin gnt_vld = 1'b1; gnt_idx = 2'd0; end
                else if (elig[1]) begin gnt_vld = 1'b1; gnt_idx = 2'd1; end
                else if (elig[2]) begin gnt_vld = 1'b1; gnt_idx = 2'd2; end
            end
        endcase
    end

    // Pointer moves just past the granted channel, wrapping 2 -> 0 so it never reaches 3
    always_comb begin
        gnt_next = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end

    // Outputs follow state and live channel status; reset state forces idle values at once
    always_comb begin
        transfer  = (state == HOLD) && gnt_vld;
        in_ready  = rdy_en && ((state == IDLE) || transfer);
        accept    = in_valid && in_ready;
        sel       = transfer ? gnt_idx : 2'b11;
        out_valid = transfer ? (3'b001 << gnt_idx) : 3'b000;
        out_data  = (state == HOLD) ? hold_reg : '0;
    end

    // Hold-register FSM: capture in IDLE, release on grant, refill on same-cycle accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            hold_reg <= '0;
            rdy_en   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold_reg <= in_data;
                        state    <= HOLD;
                    end
                end
                default: begin
                    if (transfer) begin
                        rr_ptr <= gnt_next;
                        if (accept) begin
                            hold_reg <= in_data;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef DMUX_SCHED_CNT_EN
    // Per-channel transfer counters, free-running with natural wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
            cnt2 <= '0;
        end else if (transfer) begin
            case (gnt_idx)
                2'd0:    cnt0 <= cnt0 + 1'b1;
                2'd1:    cnt1 <= cnt1 + 1'b1;
                default: cnt2 <= cnt2 + 1'b1;
            endcase
        end
    end
`endif

endmodule
